// File: rtl/mips_boot_loader.sv
// Streams a program into instruction memory while holding the MIPS core in reset,
// then releases it after a fixed settle window; overflow of the memory is latched until reset.
module mips_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0] TOP_WORD  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic            accept;
  logic            at_top;

  assign accept = (state == LOAD) && load_valid;
  // word_count doubles as the next write address; it never exceeds 2^ADDR_W
  assign at_top = (word_count == TOP_WORD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: if (accept) begin
              if (load_last)   state_nxt = HOLD;
              else if (at_top) state_nxt = ERR;
            end
      HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      RUN:  if (reload) state_nxt = LOAD;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= load_data;
        word_count <= word_count + ONE_WORD;
      end
      if (state == RUN && reload) word_count <= '0;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
    end
  end

  // All status outputs are pure state decodes: no input-to-output paths
  assign load_ready = (state == LOAD);
  assign cpu_reset  = (state != RUN);
  assign done       = (state == RUN);
  assign error      = (state == ERR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized and directed bench for mips_boot_loader against a program-level reference model.
module tb_mips_boot_loader;
  localparam int AW    = 2;
  localparam int HC    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, reset = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready, imem_we, cpu_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  int checks = 0, errors = 0;

  mips_boot_loader #(.ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference: what phase of the boot the program is in, how many words it has
  // written, and the last memory write that should be visible.
  bit          m_fresh, m_loading, m_running, m_failed;
  int          m_hold, m_count, m_addr;
  bit          m_we;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_fresh = 1; m_loading = 0; m_running = 0; m_failed = 0;
    m_hold = 0; m_count = 0; m_addr = 0; m_we = 0; m_data = '0;
  endfunction

  function automatic void m_step();
    if (!reset) begin m_reset(); return; end
    m_we = 0;
    if (m_fresh) begin
      m_fresh = 0; m_loading = 1;
    end else if (m_loading) begin
      if (load_valid) begin
        m_we = 1; m_addr = m_count % DEPTH; m_data = load_data; m_count++;
        if (load_last) begin m_loading = 0; m_hold = HC; end
        else if (m_count == DEPTH) begin m_loading = 0; m_failed = 1; end
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_running = 1;
    end else if (m_running && reload) begin
      m_running = 0; m_loading = 1; m_count = 0;
    end
  endfunction

  task automatic check_all();
    chk("load_ready", load_ready, m_loading);
    chk("imem_we",    imem_we,    m_we);
    chk("imem_addr",  imem_addr,  m_addr);
    chk("imem_wdata", imem_wdata, m_data);
    chk("word_count", word_count, m_count);
    chk("cpu_reset",  cpu_reset,  !m_running);
    chk("done",       done,       m_running);
    chk("error",      error,      m_failed);
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1 check_all();
  endtask

  task automatic send(input bit v, input logic [31:0] d, input bit l, input bit r);
    load_valid = v; load_data = d; load_last = l; reload = r;
    cycle();
  endtask

  // Assert reset between edges, check outputs before any edge, release mid-cycle.
  task automatic rst_mid();
    #2 reset = 1'b0;
    #1 m_reset();
    check_all();
    send(1, $urandom, 0, 1);
    #2 reset = 1'b1;
    send(0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    #1 check_all();
    cycle();
    #2 reset = 1'b1;
    send(0, 0, 0, 0);

    // Basic three-word program
    send(1, 32'h20080005, 0, 0);
    send(1, 32'h20090007, 0, 0);
    send(1, 32'h01095020, 1, 0);
    chk("basic_addr2", imem_addr, 2);
    load_valid = 0; load_last = 0;
    for (int i = 1; i <= HC; i++) begin
      cycle();
      chk("hold_cpu_reset", cpu_reset, (i < HC) ? 1 : 0);
    end
    chk("basic_count", word_count, 3);
    chk("basic_done", done, 1);

    // Reload then a two-word program
    send(0, 0, 0, 1);
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_done", done, 0);
    send(1, 32'hAAAA0000, 0, 0);
    send(1, 32'hAAAA0001, 1, 0);
    send(0, 0, 0, 0);
    chk("reload_count", word_count, 2);

    // Gapped valid over four words
    rst_mid();
    for (int i = 0; i < 8; i++) send(i % 2 == 0, 32'hB000 + i, i == 6, 0);
    chk("gap_count", word_count, 4);

    // Overflow: four non-last words then a fifth
    rst_mid();
    for (int i = 0; i < 5; i++) send(1, 32'hC000 + i, 0, 0);
    chk("ovf_error", error, 1);
    chk("ovf_ready", load_ready, 0);
    chk("ovf_count", word_count, DEPTH);

    // Full memory with last on the top word is a legal load
    rst_mid();
    for (int i = 0; i < 4; i++) send(1, 32'hD000 + i, i == 3, 0);
    for (int i = 0; i < HC; i++) send(0, 0, 0, 0);
    chk("full_done", done, 1);
    chk("full_error", error, 0);

    // Reload held across the whole HOLD window
    rst_mid();
    send(1, 32'hE0, 1, 0);
    for (int i = 0; i < HC; i++) send(0, 0, 0, 1);
    chk("sim_run", done, 1);
    send(0, 0, 0, 1);
    chk("sim_reload", load_ready, 1);

    // Reset mid-load after 2 of 5 words, then a fresh load from 0
    send(1, 32'hF0, 0, 0);
    send(1, 32'hF1, 0, 0);
    rst_mid();
    send(1, 32'hF5, 1, 0);
    chk("rst_addr0", imem_addr, 0);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) rst_mid();
      else send($urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, instruction-memory word-address width; HOLD_CYCLES, default 4, number of cycles cpu_reset stays high after the last word is written.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream word available.
- load_data  input  32  instruction word.
- load_last  input  1  marks the final word of the program; qualified by load_valid.
- load_ready  output  1  loader can accept a word.
- reload  input  1  request to reload the program while the core runs.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  instruction-memory word address.
- imem_wdata  output  32  instruction-memory write data.
- cpu_reset  output  1  active-high reset driven into the MIPS core.
- done  output  1  program loaded; core released.
- error  output  1  program overflowed the memory.
- word_count  output  ADDR_W+1  number of words written in the current load.

Function
REQ-003 The block SHALL use the states IDLE, LOAD, HOLD, RUN and ERR.
REQ-004 IDLE SHALL go to LOAD unconditionally on the first clock edge after reset deasserts.
REQ-005 load_ready SHALL be 1 only in LOAD; it SHALL be decoded from the state register and have no combinational path from any input.
REQ-006 A word is accepted on a rising edge where load_valid=1 and load_ready=1; no other edge accepts a word.
REQ-007 An accepted word SHALL produce imem_we=1 for exactly one cycle, starting the cycle after acceptance (1-cycle latency).
- In that cycle imem_addr SHALL equal the write address and imem_wdata the accepted data.
REQ-008 The write address SHALL start at 0 in each load and increment by 1 per accepted word.
REQ-009 word_count SHALL increment by 1 with each imem_we pulse.
REQ-010 imem_addr and imem_wdata SHALL hold their last values while imem_we=0.
REQ-011 Accepting a word with load_last=1 SHALL move the state to HOLD.
REQ-012 Accepting a word at address 2^ADDR_W-1 with load_last=0 SHALL:
- still write that word;
- move the state to ERR.
REQ-013 A word at address 2^ADDR_W-1 with load_last=1 SHALL be a legal completion and go to HOLD.
REQ-014 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to RUN.
REQ-015 cpu_reset SHALL be 1 in IDLE, LOAD, HOLD and ERR, and 0 only in RUN.
REQ-016 done SHALL be 1 only in RUN.
REQ-017 error SHALL be 1 only in ERR.
REQ-018 ERR SHALL be exited only by reset.
REQ-019 reload=1 in RUN SHALL, on that edge:
- go to LOAD;
- set cpu_reset=1 and done=0 from the next cycle;
- clear the write address and word_count to 0.
REQ-020 reload SHALL be ignored in IDLE, LOAD, HOLD and ERR.
REQ-021 load_valid and load_data SHALL be ignored outside LOAD.
REQ-022 When HOLD expiry and reload=1 fall on the same edge, the block SHALL enter RUN; reload SHALL act only from the next edge.

Reset
REQ-023 Asserting reset low SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- cpu_reset=1;
- load_ready=0, imem_we=0, done=0, error=0;
- imem_addr=0, imem_wdata=0, word_count=0.
REQ-024 Reset asserted mid-load or mid-HOLD SHALL abandon the load.
- No imem_we pulse SHALL follow the reset.
- The next load SHALL restart at address 0.
REQ-025 cpu_reset SHALL be held high throughout reset.

Verification
REQ-026 Basic load: after reset, stream 3 words 0x20080005, 0x20090007, 0x01095020, last on the third -> writes at addresses 0, 1, 2 one cycle after each acceptance; word_count=3; cpu_reset falls exactly 4 cycles after the third write; done=1.
REQ-027 Backpressure and gaps: toggle load_valid every other cycle over 4 words -> exactly 4 imem_we pulses at addresses 0-3, no duplicates or drops.
REQ-028 Overflow, ADDR_W=2: send 4 words with load_last=0 -> 4 writes at addresses 0-3, error=1, load_ready=0, cpu_reset stays 1; a fifth valid word is not written. Repeat with load_last=1 on word 4 -> HOLD then RUN, error=0.
REQ-029 Reload: in RUN pulse reload for one cycle -> cpu_reset=1 and done=0 next cycle; a new 2-word load writes addresses 0 and 1; word_count=2.
REQ-030 Async reset mid-load: assert reset between clock edges after 2 of 5 words -> all outputs take their reset values before the next edge; after release, a new load writes from address 0.
REQ-031 Simultaneous events: raise reload on the last HOLD edge -> RUN is entered; reload held one more cycle -> back to LOAD.
